trng_seq_ctrl: RTL

Sequencing controller for the TRNG datapath (sync, sample counter, balance filter, collector, CRNGT, autocorrelation, EHR). On a software/PRNG request it flushes the datapath, enables the selected ring oscillator and waits for a full EHR. It reacts to health-test failures (VN, CRNGT, autocorrelation, watchdog timeout) by retrying, then escalating to the next ROSC length, and reports a sticky failure when options run out. It sits between trng_reg_file-level control and the TRNG datapath, driving rnd_src_en, rnd_src_sel, sample_cnt and rst_trng_logic.

---
 rtl/trng_ctrl_pkg.sv | 26 ++
 rtl/trng_seq_timer.sv | 36 +++
 rtl/trng_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/trng_ctrl_pkg.sv
// Shared types and constants for the TRNG sequencing controller.
// State encoding, err_status bit positions and the highest ROSC select.
package trng_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RECOV   = 3'd4,
    ST_READY   = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  localparam int ERR_VN       = 0;
  localparam int ERR_CRNGT    = 1;
  localparam int ERR_AUTOCORR = 2;
  localparam int ERR_TIMEOUT  = 3;

  localparam logic [1:0] ROSC_MAX = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trng_seq_timer.sv
// Loadable saturating down-counter shared by the SETTLE delay and the COLLECT watchdog.
// tc_o flags the last counted cycle while enabled.
module trng_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == '0);

endmodule

// File: rtl/trng_seq_ctrl.sv
// TRNG sequencing controller: flush, settle, collect with health-test retry/escalation.
// Every output is registered and decoded from the next state.
module trng_seq_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int SAMPLE_CNT_W = 32,
  parameter int MAX_RETRY    = 3,
  parameter int SETTLE_CYC   = 16,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic                    rng_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              cfg_rosc_init,
  input  logic [SAMPLE_CNT_W-1:0] cfg_sample_cnt,
  input  logic                    cfg_auto_switch,
  input  logic                    ehr_valid,
  input  logic                    vn_err,
  input  logic                    crngt_err,
  input  logic                    autocorr_err,
  input  logic                    ehr_rd_done,
  output logic                    rnd_src_en,
  output logic [1:0]              rnd_src_sel,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt,
  output logic                    rst_trng_logic,
  output logic                    busy,
  output logic                    ready,
  output logic                    fail,
  output logic [3:0]              err_status,
  output logic [3:0]              retry_cnt
);

  localparam int TMR_W = $clog2(max_int(SETTLE_CYC, TIMEOUT_CYC) + 1);

  state_e                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]              err_q, err_d;
  logic [3:0]              retry_q, retry_d;
  logic                    flush_q, flush_d;
  logic                    en_q, busy_q, ready_q, fail_q;
  logic [3:0]              err_in;
  logic                    start_ok;
  logic                    tmr_load, tmr_en, tmr_tc;
  logic [TMR_W-1:0]        tmr_val;

  assign err_in = {1'b0, autocorr_err, crngt_err, vn_err};
  // A read-done in READY takes precedence over a new start.
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_FAIL) ||
                              ((state_q == ST_READY) && !ehr_rd_done));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    retry_d = retry_q;
    flush_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = '0;
      retry_d = '0;
      flush_d = 1'b1;
    end else if (start_ok) begin
      state_d = ST_FLUSH;
      sel_d   = cfg_rosc_init;
      cnt_d   = cfg_sample_cnt;
      err_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_FLUSH:  state_d = ST_SETTLE;
        ST_SETTLE: if (tmr_tc) state_d = ST_COLLECT;
        ST_COLLECT: begin
          if (|err_in) begin
            err_d   = err_q | err_in;
            retry_d = retry_q + 4'd1;
            state_d = ST_RECOV;
          end else if (tmr_tc) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            retry_d = retry_q + 4'd1;
            state_d = ST_RECOV;
          end else if (ehr_valid) begin
            state_d = ST_READY;
          end
        end
        ST_RECOV: begin
          if (retry_q < 4'(MAX_RETRY)) begin
            state_d = ST_FLUSH;
          end else if (cfg_auto_switch && (sel_q < ROSC_MAX)) begin
            sel_d   = sel_q + 2'd1;
            retry_d = '0;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_READY:  if (ehr_rd_done) state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
    if (state_d == ST_FLUSH) flush_d = 1'b1;
  end

  assign tmr_load = ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) ||
                    ((state_d == ST_COLLECT) && (state_q != ST_COLLECT));
  assign tmr_val  = (state_d == ST_SETTLE) ? TMR_W'(SETTLE_CYC - 1) : TMR_W'(TIMEOUT_CYC - 1);
  assign tmr_en   = (state_q == ST_SETTLE) || (state_q == ST_COLLECT);

  trng_seq_timer #(.W(TMR_W)) u_timer (
    .clk_i      (rng_clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge rng_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      retry_q <= '0;
      flush_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      flush_q <= flush_d;
      en_q    <= (state_d == ST_SETTLE) || (state_d == ST_COLLECT);
      busy_q  <= !((state_d == ST_IDLE) || (state_d == ST_READY) || (state_d == ST_FAIL));
      ready_q <= (state_d == ST_READY);
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign rnd_src_en     = en_q;
  assign rnd_src_sel    = sel_q;
  assign sample_cnt     = cnt_q;
  assign rst_trng_logic = flush_q;
  assign busy           = busy_q;
  assign ready          = ready_q;
  assign fail           = fail_q;
  assign err_status     = err_q;
  assign retry_cnt      = retry_q;

endmodule
